// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter for two result sources.
//
// The ALU port (a_*) is unbuffered and normally wins the single write port.
// The memory/long-latency port (m_*) feeds a small FIFO.
// The FIFO head is written whenever the ALU port is not granted.
// A streak counter limits how many consecutive ALU grants can starve a
// non-empty FIFO.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   rst        - synchronous, active-low reset
//   a_valid    - ALU result valid
//   a_ready    - ALU result accepted this cycle
//   a_dest     - ALU destination register
//   a_data     - ALU result value
//   m_valid    - memory result valid
//   m_ready    - FIFO can accept a memory result
//   m_dest     - memory destination register
//   m_data     - memory result value
//   write      - registered register-file write enable
//   wdest      - registered register-file write index
//   wdata      - registered register-file write data
//   fifo_count - current FIFO occupancy
//   pending    - FIFO non-empty or a write in progress
module wb_arbiter #(
    parameter int REG_BITS     = 5,
    parameter int REG_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int WB_ZERO      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [REG_BITS-1:0]           a_dest,
    input  logic [REG_WIDTH-1:0]          a_data,
    input  logic                          m_valid,
    output logic                          m_ready,
    input  logic [REG_BITS-1:0]           m_dest,
    input  logic [REG_WIDTH-1:0]          m_data,
    output logic                          write,
    output logic [REG_BITS-1:0]           wdest,
    output logic [REG_WIDTH-1:0]          wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          pending
);

    localparam int PTR_BITS    = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS    = PTR_BITS + 1;
    localparam int STREAK_BITS = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [REG_BITS+REG_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]           rd_ptr;
    logic [PTR_BITS-1:0]           wr_ptr;
    logic [CNT_BITS-1:0]           count;
    logic [STREAK_BITS-1:0]        streak;

    logic                          fifo_empty;
    logic                          starve;
    logic                          a_grant;
    logic                          push;
    logic                          pop;
    logic [REG_BITS-1:0]           head_dest;
    logic [REG_WIDTH-1:0]          head_data;
    logic [REG_BITS-1:0]           sel_dest;
    logic [REG_WIDTH-1:0]          sel_data;

    // Handshakes and grant selection. The ALU port is refused only when the
    // FIFO has waited through STARVE_LIMIT consecutive ALU grants. The FIFO
    // pop is gated by rst so nothing is consumed during reset.
    always_comb begin
        fifo_empty             = (count == '0);
        starve                 = !fifo_empty && (streak == STREAK_BITS'(STARVE_LIMIT));
        a_ready                = rst && !starve;
        m_ready                = rst && (count < CNT_BITS'(FIFO_DEPTH));
        a_grant                = a_valid && a_ready;
        push                   = m_valid && m_ready;
        pop                    = rst && !a_grant && !fifo_empty;
        {head_dest, head_data} = mem[rd_ptr];
        sel_dest               = a_grant ? a_dest : head_dest;
        sel_data               = a_grant ? a_data : head_data;
    end

    // FIFO storage. The push is already qualified by rst through m_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {m_dest, m_data};
        end
    end

    // Pointers are exactly PTR_BITS wide.
    // Because the depth is a power of two, they wrap without extra logic.
    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation streak: counts ALU grants taken while the FIFO waits.
    // It restarts whenever the FIFO gets its turn or has nothing queued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
        end else if (pop || fifo_empty) begin
            streak <= '0;
        end else if (a_grant && (streak != STREAK_BITS'(STARVE_LIMIT))) begin
            streak <= streak + 1'b1;
        end
    end

    // Registered write port. A grant to register 0 still consumes the entry
    // but suppresses the enable unless WB_ZERO permits it. wdest/wdata hold
    // their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write <= 1'b0;
            wdest <= '0;
            wdata <= '0;
        end else if (a_grant || pop) begin
            write <= (WB_ZERO != 0) || (sel_dest != '0);
            wdest <= sel_dest;
            wdata <= sel_data;
        end else begin
            write <= 1'b0;
        end
    end

    assign fifo_count = count;
    assign pending    = !fifo_empty || write;

endmodule
